// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-and-add-3).
//
// Converts an unsigned W-bit value (W = 1..9, max 511) to three BCD digits.
// One conversion takes W+1 clocks after the accepting edge: W shift
// iterations, then one edge that publishes the digits and pulses done.
//
// Ports
//   clk       system clock, rising edge
//   button0   asynchronous active-low reset
//   start     conversion request, sampled every edge, honoured only in IDLE
//   bin       value to convert, latched on the accepting edge
//   busy      high from the accepting edge until the publishing edge
//   done      one-cycle pulse: new result on the digit outputs
//   bcd_hund  hundreds digit (0..5)
//   bcd_tens  tens digit (0..9)
//   bcd_ones  ones digit (0..9)
// -----------------------------------------------------------------------------

// Per-digit correction: a digit >= 5 would overflow past 9 after the next
// left shift, so add 3 first. 4-bit add, no carry into the next digit.
module bin2bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         button0,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [3:0]   bcd_hund,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones
);
  localparam int NDIG = 3;
  localparam int CW   = (W < 2) ? 1 : $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [11:0]    scr;       // scratch BCD: hund[11:8] tens[7:4] ones[3:0]
  logic [W-1:0]   sr;        // binary shift register, MSB first
  logic [CW-1:0]  cnt;       // completed shift iterations
  logic [11:0]    scr_adj;   // scratch after add-3 correction
  logic [W+11:0]  cat_sh;    // {scr_adj, sr} shifted left by one

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bin2bcd_add3 u_add3 (
      .d (scr[4*g +: 4]),
      .q (scr_adj[4*g +: 4])
    );
  end

  // The binary MSB enters the ones digit LSB; the top scratch bit falls out
  // (it is always zero for in-range values).
  assign cat_sh = {scr_adj, sr} << 1;

  always_ff @(posedge clk or negedge button0) begin
    if (!button0) begin
      state    <= IDLE;
      scr      <= '0;
      sr       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_hund <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
    end else begin
      case (state)
        IDLE: begin
          // done drops here, so a back-to-back start on the edge after the
          // pulse both clears done and raises busy.
          done <= 1'b0;
          if (start) begin
            sr    <= bin;
            scr   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= cat_sh[W+11:W];
          sr  <= cat_sh[W-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= DONE;
        end
        DONE: begin
          // Only place the visible digits change; partial scratch never leaks.
          bcd_hund <= scr[11:8];
          bcd_tens <= scr[7:4];
          bcd_ones <= scr[3:0];
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
  logic       clk = 1'b0;
  logic       button0 = 1'b0;
  logic       start8 = 1'b0, start9 = 1'b0;
  logic [7:0] bin8 = '0;
  logic [8:0] bin9 = '0;
  logic       busy8, done8, busy9, done9;
  logic [3:0] h8, t8, o8, h9, t9, o9;

  bin2bcd_seq #(.W(8)) u_dut8 (
    .clk(clk), .button0(button0), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd_hund(h8), .bcd_tens(t8), .bcd_ones(o8)
  );
  bin2bcd_seq #(.W(9)) u_dut9 (
    .clk(clk), .button0(button0), .start(start9), .bin(bin9),
    .busy(busy9), .done(done9), .bcd_hund(h9), .bcd_tens(t9), .bcd_ones(o9)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] h, t, o;
    int         due;
  } exp_t;

  exp_t q8[$], q9[$];
  int tests = 0, fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expected results whenever a DUT pulses done.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        chk("hund8", h8, e.h); chk("tens8", t8, e.t); chk("ones8", o8, e.o);
        chk("latency8", cyc, e.due);
      end
    end
    if (done9 === 1'b1) begin
      if (q9.size() == 0) chk("done9_unexpected", 1, 0);
      else begin
        e = q9.pop_front();
        chk("hund9", h9, e.h); chk("tens9", t9, e.t); chk("ones9", o9, e.o);
        chk("latency9", cyc, e.due);
      end
    end
    if (busy8 === 1'b1 && done8 === 1'b1) chk("busy_done_excl8", 1, 0);
    if (busy9 === 1'b1 && done9 === 1'b1) chk("busy_done_excl9", 1, 0);
  end

  // Called at a negedge; issues one request once the W=8 DUT is idle and
  // returns at the negedge after the accepting edge.
  task automatic conv8(input logic [7:0] v, input logic [3:0] h, t, o);
    exp_t e;
    int n = 0;
    while (busy8 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout8", 0, 1);
    start8 = 1'b1; bin8 = v;
    e.h = h; e.t = t; e.o = o; e.due = cyc + 10;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; bin8 = 8'($urandom);
    chk("busy_after_accept8", busy8, 1);
  endtask

  task automatic conv9(input logic [8:0] v, input logic [3:0] h, t, o);
    exp_t e;
    int n = 0;
    while (busy9 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout9", 0, 1);
    start9 = 1'b1; bin9 = v;
    e.h = h; e.t = t; e.o = o; e.due = cyc + 11;
    q9.push_back(e);
    @(negedge clk);
    start9 = 1'b0; bin9 = 9'($urandom);
    chk("busy_after_accept9", busy9, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q9.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    // Reset state without any clock edge seen
    #1;
    chk("rst_busy", busy8, 0); chk("rst_done", done8, 0);
    chk("rst_digits", {h8, t8, o8}, 0);
    chk("rst_busy9", busy9, 0); chk("rst_digits9", {h9, t9, o9}, 0);
    @(negedge clk); @(negedge clk);
    button0 = 1'b1;
    @(negedge clk);

    // 255: busy across edges 1..8, done only after edge 9
    conv8(8'd255, 4'd2, 4'd5, 4'd5);
    repeat (8) begin
      @(negedge clk);
      chk("busy_window", busy8, 1); chk("done_low_window", done8, 0);
    end
    @(negedge clk);
    chk("done_pulse", done8, 1); chk("busy_clear", busy8, 0);
    @(negedge clk);
    chk("done_falls", done8, 0);
    chk("digits_hold", {h8, t8, o8}, 12'h255);

    conv8(8'd0,   4'd0, 4'd0, 4'd0);
    conv8(8'd99,  4'd0, 4'd9, 4'd9);
    conv8(8'd100, 4'd1, 4'd0, 4'd0);
    drain();

    // 37 with start held and bin changed during SHIFT: one result only
    begin : held
      exp_t e;
      start8 = 1'b1; bin8 = 8'd37;
      e.h = 4'd0; e.t = 4'd3; e.o = 4'd7; e.due = cyc + 10;
      q8.push_back(e);
      repeat (7) begin @(negedge clk); bin8 = 8'd200; end
      start8 = 1'b0;
    end
    drain();
    repeat (5) @(negedge clk);
    chk("held_single", q8.size(), 0);

    // Back-to-back: 10 then 200 accepted on the edge after done
    conv8(8'd10,  4'd0, 4'd1, 4'd0);
    conv8(8'd200, 4'd2, 4'd0, 4'd0);
    drain();

    // Mid-conversion reset
    conv8(8'd123, 4'd1, 4'd2, 4'd3);
    drain();
    conv8(8'd45, 4'd0, 4'd4, 4'd5);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 button0 = 1'b0;
    q8.delete();
    #1;
    chk("midrst_busy", busy8, 0); chk("midrst_done", done8, 0);
    chk("midrst_digits", {h8, t8, o8}, 0);
    repeat (12) @(negedge clk);
    chk("midrst_still_zero", {h8, t8, o8}, 0);
    button0 = 1'b1;
    conv8(8'd45, 4'd0, 4'd4, 4'd5);
    drain();

    // Exhaustive sweeps, both widths in parallel
    fork
      begin
        for (int v = 0; v < 256; v++)
          conv8(8'(v), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
      end
      begin
        for (int u = 0; u < 512; u++)
          conv9(9'(u), 4'(u / 100), 4'((u / 10) % 10), 4'(u % 10));
      end
    join
    drain();
    chk("sweep9_last_hund", h9, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: W, default 8, binary input width; legal range 1..9, so the result always fits three BCD digits (max 511).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 button0  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  conversion request, level-sampled on each rising clk edge.
REQ-005 bin  input  W  unsigned binary value to convert; sampled only when start is accepted.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking a new result on the digit outputs.
REQ-008 bcd_hund  output  4  hundreds digit, 0..5.
REQ-009 bcd_tens  output  4  tens digit, 0..9.
REQ-010 bcd_ones  output  4  ones digit, 0..9.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 at an edge (edge 0): bin is latched into the shift register, the 12-bit scratch BCD is cleared, the iteration count is cleared, busy is set to 1 and the FSM goes to SHIFT.
REQ-013 IDLE with start=0: no state change; the digit outputs hold their values.
REQ-014 On each SHIFT edge: each scratch digit >=5 gets +3 (4-bit add, no carry between digits), then {scratch, shift register} shifts left by one bit; the iteration count increments.
REQ-015 SHIFT SHALL perform exactly W iterations, on edges 1..W; the edge that completes iteration W moves the FSM to DONE.
REQ-016 DONE edge (edge W+1): the scratch digits are copied to bcd_hund/bcd_tens/bcd_ones, done is set to 1, busy is cleared and the FSM returns to IDLE.
REQ-017 done SHALL be high for exactly one cycle, from edge W+1 to edge W+2; it is low at all other times.
REQ-018 Latency: the result is visible W+1 edges after the accepting edge; for W=8 that is 9 cycles.
REQ-019 start is ignored in SHIFT and DONE; no queuing and no restart.
REQ-020 Changes on bin after the accepting edge SHALL NOT affect the result in flight.
REQ-021 Back-to-back: start=1 on edge W+2 (FSM in IDLE, done high) is accepted; done falls and busy rises on that same edge.
REQ-022 The digit outputs change only on a DONE edge or on reset; they are never updated with partial scratch values.
REQ-023 The outputs SHALL equal floor(bin/100), floor(bin/10) mod 10 and bin mod 10 of the accepted value, for every value in 0..2^W-1.
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 When button0=0, with no clock required: FSM=IDLE, busy=0, done=0, all digit outputs=0, scratch, shift register and count=0.
REQ-026 A reset asserted mid-conversion SHALL abandon the conversion; no done pulse follows, and the digits read 0 after reset.
REQ-027 After button0 rises, start is honoured from the first clk edge at which it is sampled high.

Verification
REQ-028 W=8, bin=255, start pulsed at edge 0 -> busy high over edges 0..9; done=1 only between edges 9 and 10; digits 2/5/5.
REQ-029 bin=0 -> digits 0/0/0 with done at edge 9; bin=99 -> 0/9/9; bin=100 -> 1/0/0.
REQ-030 Convert 37; start=1 held and bin changed to 200 during SHIFT -> a single done, digits 0/3/7, no second conversion until the FSM is in IDLE.
REQ-031 Back-to-back: convert 10, start=1 on edge 10 with bin=200 -> first done shows 0/1/0, second done at edge 19 shows 2/0/0.
REQ-032 Convert 123 to completion, then convert 45 and drive button0 low at edge 4 -> all outputs 0 immediately, no done pulse; a fresh conversion of 45 then gives 0/4/5.
REQ-033 Exhaustive sweep of bin 0..255 against the REQ-023 reference model; W=9 sweep 0..511 with the hundreds digit reaching 5.
